// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

    localparam int N_DIGITS = 5;
    localparam int ITER     = 4 * N_DIGITS;
    localparam int OUT_W    = 16;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // True when any nibble of a packed digit vector is not a legal BCD digit.
    function automatic logic bad_digit(input logic [4*N_DIGITS-1:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digits[4*i +: 4] > BCD_MAX) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One digit of the reverse double-dabble correction: digits >= 8 lose 3.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd2bin_16.sv
// Five-digit BCD to 16-bit binary converter, reverse double-dabble, one shift per cycle.
// Build option: define BCD2BIN_SATURATE_EN to clamp overflowing results to 16'hFFFF.
module bcd2bin_16
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       bcd0,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd2,
    input  logic [3:0]       bcd3,
    input  logic [3:0]       bcd4,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] bin,
    output logic             ovf,
    output logic             err
);

    localparam int DW = 4 * N_DIGITS;

    state_t           state_reg, state_next;
    logic [DW-1:0]    digit_reg, digit_next;
    logic [DW-1:0]    result_reg, result_next;
    logic [4:0]       cnt_reg, cnt_next;
    logic [OUT_W-1:0] bin_reg, bin_next;
    logic             ovf_reg, ovf_next;
    logic             err_reg, err_next;

    logic [DW-1:0]    shift_dig;
    logic [DW-1:0]    adj_dig;
    logic [DW-1:0]    shift_res;
    logic [OUT_W-1:0] final_bin;
    logic             final_ovf;

    // The digit LSB falls into the result MSB on every shift.
    assign shift_dig = {1'b0, digit_reg[DW-1:1]};
    assign shift_res = {digit_reg[0], result_reg[DW-1:1]};

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (shift_dig[4*gi +: 4]),
                .dout (adj_dig[4*gi +: 4])
            );
        end
    endgenerate

    assign final_ovf = |shift_res[DW-1:OUT_W];

`ifdef BCD2BIN_SATURATE_EN
    assign final_bin = final_ovf ? {OUT_W{1'b1}} : shift_res[OUT_W-1:0];
`else
    assign final_bin = shift_res[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            digit_reg  <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            bin_reg    <= '0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            digit_reg  <= digit_next;
            result_reg <= result_next;
            cnt_reg    <= cnt_next;
            bin_reg    <= bin_next;
            ovf_reg    <= ovf_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        digit_next  = digit_reg;
        result_next = result_reg;
        cnt_next    = cnt_reg;
        bin_next    = bin_reg;
        ovf_next    = ovf_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    digit_next  = {bcd4, bcd3, bcd2, bcd1, bcd0};
                    result_next = '0;
                    cnt_next    = '0;
                    if (bad_digit({bcd4, bcd3, bcd2, bcd1, bcd0})) begin
                        // Illegal digits skip the conversion entirely.
                        bin_next   = '0;
                        ovf_next   = 1'b0;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = CONV;
                    end
                end
            end
            CONV: begin
                digit_next  = adj_dig;
                result_next = shift_res;
                cnt_next    = cnt_reg + 5'd1;
                if (cnt_reg == 5'(ITER - 1)) begin
                    bin_next   = final_bin;
                    ovf_next   = final_ovf;
                    err_next   = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == CONV);
    assign done = (state_reg == DONE);
    assign bin  = bin_reg;
    assign ovf  = ovf_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd2bin_16.sv
// Scoreboard bench for bcd2bin_16: directed corner cases plus random digit sets.
module tb_bcd2bin_16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0, bcd4 = '0;
    logic        busy, done, ovf, err;
    logic [15:0] bin;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [15:0] bin;
        logic        ovf;
        logic        err;
        int          cyc;
        int          busy;
        logic [19:0] digits;
    } exp_t;

    exp_t sb[$];

    bcd2bin_16 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd0  (bcd0),
        .bcd1  (bcd1),
        .bcd2  (bcd2),
        .bcd3  (bcd3),
        .bcd4  (bcd4),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .ovf   (ovf),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: decimal value by plain arithmetic, then the output rules.
    function automatic exp_t model(input logic [19:0] d, input int acc_cyc);
        exp_t e;
        int   value;
        logic bad;
        value = 0;
        bad   = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (d[4*i +: 4] > 4'd9) bad = 1'b1;
            value = value * 10 + int'(d[4*i +: 4]);
        end
        e.digits = d;
        e.err    = bad;
        e.ovf    = !bad && (value > 65535);
        if (bad) e.bin = 16'h0000;
`ifdef BCD2BIN_SATURATE_EN
        else if (value > 65535) e.bin = 16'hFFFF;
`endif
        else e.bin = 16'(value % 65536);
        e.cyc  = bad ? acc_cyc : acc_cyc + 20;
        e.busy = bad ? 0 : 20;
        return e;
    endfunction

    task automatic set_digits(input logic [19:0] d);
        {bcd4, bcd3, bcd2, bcd1, bcd0} = d;
    endtask

    task automatic issue(input logic [19:0] d);
        @(negedge clk);
        set_digits(d);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(d, cyc));
        set_digits(20'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                $display("[TB] digits %05h -> bin %04h ovf %0d err %0d", e.digits, bin, ovf, err);
                chk("bin", int'(bin), int'(e.bin));
                chk("ovf", int'(ovf), int'(e.ovf));
                chk("err", int'(err), int'(e.err));
                chk("done_cycle", cyc, e.cyc);
                chk("busy_cycles", busy_cnt, e.busy);
            end
            busy_cnt = 0;
        end
    end

    initial begin
        int e0;
        logic [19:0] d;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_bin", int'(bin), 0);
        rst = 1'b0;

        issue(20'h12345); drain();
        issue(20'h65535); drain();
        issue(20'h00000); drain();
        issue(20'h65536); drain();
        issue(20'h99999); drain();
        issue(20'h00A00); drain();

        for (int i = 0; i < 25; i++) begin
            d = 20'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 5; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            issue(d);
            drain();
        end

        // Reset during conversion: outputs clear and no result follows.
        issue(20'h12345);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        $display("[TB] reset mid-conversion");
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_bin", int'(bin), 0);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_err", int'(err), 0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        issue(20'h00042); drain();

        // Start held high with digits changing mid-conversion.
        @(negedge clk);
        set_digits(20'h54321);
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        sb.push_back(model(20'h54321, e0));
        sb.push_back(model(20'h09876, e0 + 22));
        repeat (5) @(posedge clk);
        #1;
        set_digits(20'h09876);
        repeat (17) @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
